weight_fetch_ctrl: RTL and testbench

Read-side controller for one per-neuron weight BRAM of DEPTH x DW words. The BRAM captures its address and enable on the falling clock edge. On START, the block drives BRAM address/enable to read every word in order, 0..DEPTH-1. It returns the words to the downstream MAC datapath as a valid/ready stream with index and last markers. Backpressure never drops or duplicates a word.

---
 rtl/weight_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Read-side fetch controller for a per-neuron weight BRAM (falling-edge BRAM, 1-cycle latency).
// Optional WFETCH_CHECKSUM_EN adds CHKSUM, the running modulo-2^DW sum of handshaken words.
module weight_fetch_ctrl #(
   parameter int unsigned DEPTH = 28,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          START,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW-1:0] BRAM_ADDR,
   output logic          BRAM_EN,
   output logic          BRAM_WE,
   input  logic [DW-1:0] BRAM_DO,
   output logic [DW-1:0] W_DATA,
   output logic [AW-1:0] W_INDEX,
   output logic          W_VALID,
   input  logic          W_READY,
`ifdef WFETCH_CHECKSUM_EN
   output logic          W_LAST,
   output logic [DW-1:0] CHKSUM
`else
   output logic          W_LAST
`endif
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] idx;
      logic          last;
   } entry_t;

   state_e        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] bram_addr_q, bram_addr_d;
   logic          bram_en_q, bram_en_d;
   logic [1:0]    cnt_q, cnt_d;
   entry_t        ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
   logic          pop, push, issue, start_acc;
   logic [2:0]    occ;

   // A read registered last edge is in flight, so bram_en_q doubles as the in-flight flag.
   always_comb begin
      pop       = (cnt_q != 2'd0) && W_READY;
      push      = bram_en_q;
      start_acc = (state_q == S_IDLE) && START;
      occ       = 3'(cnt_q) + 3'(bram_en_q) - 3'(pop);
      // In FETCH the pointer is always below DEPTH: the last issue leaves FETCH.
      issue     = (state_q == S_FETCH) && (occ < 3'd2);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_FETCH;
         S_FETCH: if (issue && (ptr_q == LAST_ADDR)) state_d = S_DRAIN;
         S_DRAIN: if (!bram_en_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)))
                     state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      BUSY    = (state_q == S_FETCH) || (state_q == S_DRAIN);
      DONE    = (state_q == S_DONE);
      BRAM_ADDR = bram_addr_q;
      BRAM_EN = bram_en_q;
      W_VALID = (cnt_q != 2'd0);
      W_DATA  = ent0_q.data;
      W_INDEX = ent0_q.idx;
      W_LAST  = W_VALID && ent0_q.last;
   end

   assign BRAM_WE = 1'b0;

   always_comb begin
      ptr_d = ptr_q;
      if (start_acc)                          ptr_d = '0;
      else if (issue && (ptr_q != LAST_ADDR)) ptr_d = ptr_q + 1'b1;
      bram_en_d   = issue;
      bram_addr_d = issue ? ptr_q : bram_addr_q;
   end

   // Two-entry skid FIFO; ent0 is the head presented downstream.
   always_comb begin
      new_ent.data = BRAM_DO;
      new_ent.idx  = bram_addr_q;
      new_ent.last = (bram_addr_q == LAST_ADDR);
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) ent0_d = new_ent;
            else               ent1_d = new_ent;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = new_ent;
            end else begin
               ent0_d = ent1_q;
               ent1_d = new_ent;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q       <= '0;
         bram_addr_q <= '0;
         bram_en_q   <= 1'b0;
         cnt_q       <= '0;
         ent0_q      <= '0;
         ent1_q      <= '0;
      end else begin
         ptr_q       <= ptr_d;
         bram_addr_q <= bram_addr_d;
         bram_en_q   <= bram_en_d;
         cnt_q       <= cnt_d;
         ent0_q      <= ent0_d;
         ent1_q      <= ent1_d;
      end
   end

`ifdef WFETCH_CHECKSUM_EN
   logic [DW-1:0] chk_q, chk_d;

   always_comb begin
      chk_d = chk_q;
      if (start_acc) chk_d = '0;
      else if (pop)  chk_d = chk_q + ent0_q.data;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) chk_q <= '0;
      else        chk_q <= chk_d;
   end

   assign CHKSUM = chk_q;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed self-checking bench for weight_fetch_ctrl with a falling-edge BRAM model.
// Checksum checks are built only when WFETCH_CHECKSUM_EN is defined.
module tb_weight_fetch_ctrl;

   localparam int DEPTH = 28;
   localparam int AW    = 5;
   localparam int DW    = 16;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          START;
   logic          BUSY, DONE;
   logic [AW-1:0] BRAM_ADDR;
   logic          BRAM_EN, BRAM_WE;
   logic [DW-1:0] BRAM_DO;
   logic [DW-1:0] W_DATA;
   logic [AW-1:0] W_INDEX;
   logic          W_VALID, W_READY, W_LAST;
`ifdef WFETCH_CHECKSUM_EN
   logic [DW-1:0] CHKSUM;
   logic [DW-1:0] r_chk_done, r_chk_after;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   int r_words, r_bad, r_unstable, r_done, r_done_cyc, r_overfill;
   int r_first_en, r_first_valid, r_we, r_en_early, r_busy_bad;
   logic [DW-1:0] r_hold_data;
   logic [AW-1:0] r_hold_idx;
   logic          r_hold_valid;

   logic [DW-1:0] mem [0:31];

   always #5 CLK = ~CLK;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = DW'(i * 3 + 1);
      BRAM_DO = '0;
   end

   always @(negedge CLK) begin
      if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];
   end

   weight_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY), .DONE(DONE),
      .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_DO(BRAM_DO),
      .W_DATA(W_DATA), .W_INDEX(W_INDEX), .W_VALID(W_VALID), .W_READY(W_READY),
`ifdef WFETCH_CHECKSUM_EN
      .W_LAST(W_LAST), .CHKSUM(CHKSUM)
`else
      .W_LAST(W_LAST)
`endif
   );

   // Called at #1 after an edge; returns at #1 after the edge that samples START (cycle 0).
   task automatic pulse_start;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   // Drives W_READY/START per cycle from cycle 0 and gathers stream statistics.
   task automatic run_burst(input logic [15:0] pat, input int hold, input int s1, input int s2);
      int cyc = 0;
      int issued = 0;
      logic prev_hold = 1'b0;
      logic exp_busy;
      logic [DW+AW+1:0] prev_out = '0;
      r_words = 0; r_bad = 0; r_unstable = 0; r_done = 0; r_done_cyc = -1;
      r_overfill = 0; r_first_en = -1; r_first_valid = -1; r_we = 0;
      r_en_early = 0; r_busy_bad = 0;
      while (cyc < 200) begin
         if (BRAM_WE !== 1'b0) r_we++;
         if (BRAM_EN === 1'b1) begin
            if (r_first_en < 0) r_first_en = cyc;
            if (cyc <= hold) r_en_early++;
            if (BRAM_ADDR !== AW'(issued)) r_bad++;
            issued++;
         end
         if (issued - r_words > 2) r_overfill++;
         if (prev_hold && ({W_VALID, W_LAST, W_INDEX, W_DATA} !== prev_out)) r_unstable++;
         if (W_VALID === 1'b1 && r_first_valid < 0) r_first_valid = cyc;
         exp_busy = (r_done == 0) && (DONE !== 1'b1);
         if (BUSY !== exp_busy) r_busy_bad++;
         if (DONE === 1'b1) begin
            r_done++;
            r_done_cyc = cyc;
`ifdef WFETCH_CHECKSUM_EN
            r_chk_done = CHKSUM;
`endif
         end
`ifdef WFETCH_CHECKSUM_EN
         if (r_done > 0 && cyc == r_done_cyc + 1) r_chk_after = CHKSUM;
`endif
         if (cyc == hold) begin
            r_hold_valid = W_VALID;
            r_hold_idx   = W_INDEX;
            r_hold_data  = W_DATA;
         end
         START   = (cyc == s1) || (cyc == s2);
         W_READY = (cyc < hold) ? 1'b0 : pat[cyc % 16];
         if (W_VALID === 1'b1 && W_READY) begin
            if (W_INDEX !== AW'(r_words) || W_DATA !== DW'(r_words * 3 + 1) ||
                W_LAST !== (r_words == DEPTH - 1)) r_bad++;
            r_words++;
         end
         prev_hold = (W_VALID === 1'b1) && !W_READY;
         prev_out  = {W_VALID, W_LAST, W_INDEX, W_DATA};
         if (r_done > 0 && cyc >= r_done_cyc + 2) break;
         @(posedge CLK); #1;
         cyc++;
      end
      START   = 1'b0;
      W_READY = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge CLK);
      #1;
      n_tests++;
      if ({BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_INDEX, W_VALID, W_LAST} !== '0) begin
         n_fail++;
         $display("FAIL reset_held outputs=%h want 0",
                  {BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_INDEX, W_VALID, W_LAST});
      end
      RST_N = 1'b1;
      @(posedge CLK); #1;
      n_tests++;
      if ({BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_INDEX, W_VALID, W_LAST} !== '0) begin
         n_fail++;
         $display("FAIL reset_idle outputs=%h want 0",
                  {BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_INDEX, W_VALID, W_LAST});
      end
`ifdef WFETCH_CHECKSUM_EN
      n_tests++;
      if (CHKSUM !== '0) begin
         n_fail++;
         $display("FAIL reset_chksum got %0d want 0", CHKSUM);
      end
`endif
   endtask

   task automatic test_stream;
      pulse_start;
      run_burst(16'hFFFF, -1, -1, -1);
      n_tests++;
      if (r_first_en !== 1) begin n_fail++; $display("FAIL stream_first_en got %0d want 1", r_first_en); end
      n_tests++;
      if (r_first_valid !== 2) begin n_fail++; $display("FAIL stream_first_valid got %0d want 2", r_first_valid); end
      n_tests++;
      if (r_words !== 28) begin n_fail++; $display("FAIL stream_words got %0d want 28", r_words); end
      n_tests++;
      if (r_bad !== 0) begin n_fail++; $display("FAIL stream_order bad=%0d want 0", r_bad); end
      n_tests++;
      if (r_done !== 1 || r_done_cyc !== 30) begin
         n_fail++; $display("FAIL stream_done count=%0d cyc=%0d want 1 at 30", r_done, r_done_cyc);
      end
      n_tests++;
      if (r_busy_bad !== 0) begin n_fail++; $display("FAIL stream_busy bad=%0d want 0", r_busy_bad); end
      n_tests++;
      if (r_we !== 0) begin n_fail++; $display("FAIL stream_bram_we seen=%0d want 0", r_we); end
`ifdef WFETCH_CHECKSUM_EN
      n_tests++;
      if (r_chk_done !== 16'd1162 || r_chk_after !== 16'd1162) begin
         n_fail++; $display("FAIL chksum_done got %0d/%0d want 1162", r_chk_done, r_chk_after);
      end
`endif
   endtask

`ifdef WFETCH_CHECKSUM_EN
   task automatic test_checksum_clear;
      pulse_start;
      n_tests++;
      if (CHKSUM !== '0) begin n_fail++; $display("FAIL chksum_clear got %0d want 0", CHKSUM); end
      run_burst(16'hFFFF, -1, -1, -1);
      n_tests++;
      if (r_chk_done !== 16'd1162) begin
         n_fail++; $display("FAIL chksum_second got %0d want 1162", r_chk_done);
      end
   endtask
`endif

   task automatic test_backpressure;
      pulse_start;
      run_burst(16'h9C5A, -1, -1, -1);
      n_tests++;
      if (r_words !== 28 || r_bad !== 0) begin
         n_fail++; $display("FAIL bp_sequence words=%0d bad=%0d want 28/0", r_words, r_bad);
      end
      n_tests++;
      if (r_unstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d want 0", r_unstable); end
      n_tests++;
      if (r_overfill !== 0) begin n_fail++; $display("FAIL bp_overfill got %0d want 0", r_overfill); end
      n_tests++;
      if (r_done !== 1) begin n_fail++; $display("FAIL bp_done count=%0d want 1", r_done); end
   endtask

   task automatic test_stall;
      W_READY = 1'b0;
      pulse_start;
      run_burst(16'hFFFF, 10, -1, -1);
      n_tests++;
      if (r_en_early !== 2) begin n_fail++; $display("FAIL stall_en_pulses got %0d want 2", r_en_early); end
      n_tests++;
      if (r_hold_valid !== 1'b1 || r_hold_idx !== '0 || r_hold_data !== 16'd1) begin
         n_fail++;
         $display("FAIL stall_head valid=%0d idx=%0d data=%0d want 1/0/1", r_hold_valid, r_hold_idx, r_hold_data);
      end
      n_tests++;
      if (r_words !== 28 || r_bad !== 0 || r_overfill !== 0) begin
         n_fail++; $display("FAIL stall_resume words=%0d bad=%0d over=%0d want 28/0/0", r_words, r_bad, r_overfill);
      end
      n_tests++;
      if (r_done !== 1 || r_done_cyc !== 38) begin
         n_fail++; $display("FAIL stall_done count=%0d cyc=%0d want 1 at 38", r_done, r_done_cyc);
      end
   endtask

   task automatic test_restart_ignored;
      pulse_start;
      run_burst(16'hFFFF, -1, 5, 20);
      n_tests++;
      if (r_words !== 28 || r_bad !== 0) begin
         n_fail++; $display("FAIL restart_sequence words=%0d bad=%0d want 28/0", r_words, r_bad);
      end
      n_tests++;
      if (r_done !== 1 || r_done_cyc !== 30) begin
         n_fail++; $display("FAIL restart_done count=%0d cyc=%0d want 1 at 30", r_done, r_done_cyc);
      end
   endtask

   task automatic test_midburst_reset;
      W_READY = 1'b1;
      pulse_start;
      for (int i = 0; i < 40 && !(W_VALID === 1'b1 && W_INDEX === 5'd12); i++) begin
         @(posedge CLK); #1;
      end
      n_tests++;
      if (W_VALID !== 1'b1 || W_INDEX !== 5'd12) begin
         n_fail++; $display("FAIL midrst_reach valid=%0d idx=%0d want 1/12", W_VALID, W_INDEX);
      end
      @(posedge CLK); #1;
      n_tests++;
      if (W_INDEX !== 5'd13 || BUSY !== 1'b1) begin
         n_fail++; $display("FAIL midrst_pre idx=%0d busy=%0d want 13/1", W_INDEX, BUSY);
      end
      #2;
      RST_N = 1'b0;
      #1;
      n_tests++;
      if ({BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_INDEX, W_VALID, W_LAST} !== '0) begin
         n_fail++;
         $display("FAIL midrst_async outputs=%h want 0",
                  {BUSY, DONE, BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_INDEX, W_VALID, W_LAST});
      end
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      pulse_start;
      run_burst(16'hFFFF, -1, -1, -1);
      n_tests++;
      if (r_words !== 28 || r_bad !== 0 || r_first_valid !== 2) begin
         n_fail++;
         $display("FAIL midrst_restart words=%0d bad=%0d first=%0d want 28/0/2", r_words, r_bad, r_first_valid);
      end
      n_tests++;
      if (r_done !== 1 || r_done_cyc !== 30) begin
         n_fail++; $display("FAIL midrst_done count=%0d cyc=%0d want 1 at 30", r_done, r_done_cyc);
      end
   endtask

   initial begin
      RST_N   = 1'b0;
      START   = 1'b0;
      W_READY = 1'b1;
      test_reset;
      test_stream;
`ifdef WFETCH_CHECKSUM_EN
      test_checksum_clear;
`endif
      test_backpressure;
      test_stall;
      test_restart_ignored;
      test_midburst_reset;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
